ntt_buffer_ram_resp: RTL and testbench
======================================

Name: ntt_buffer_ram_resp

Overview:
- Responder end of the buffer-RAM interface that the NTT/iNTT controllers drive.
- Holds one E-lane coefficient buffer: DEPTH words of E*FSIZE bits.
- Controller side: fixed-latency reads every cycle plus write-back.
- Host side: single-word load/unload port, usable only while no transform is running.

Parameters:
- E, 8, lanes per word; power of two.
- FSIZE, 64, bits per coefficient.
- DEPTH, 512, words in buffer (N/E); power of two.
- READ_LATENCY, 2, raddr-to-rdata cycles; equals package BUFFER_READ_LATENCY; must be >= 1.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- ctrl_active  in  1  transform running (controller NTT_working); ctrl side owns the RAM.
- ctrl_in  in  BufferRAMTEFsizeInputs  raddr, waddr, wren, wdata from controller.
- ctrl_rdata  out  E*FSIZE  read data, READ_LATENCY after raddr.
- host_req_valid  in  1  host request.
- host_req_ready  out  1  request accepted when valid & ready.
- host_req_we  in  1  1 = write, 0 = read.
- host_req_addr  in  clog2(DEPTH)  word address.
- host_req_wdata  in  E*FSIZE  write data.
- host_rsp_valid  out  1  one-cycle pulse with read data.
- host_rsp_rdata  out  E*FSIZE  host read data.
- ctrl_wr_count  out  clog2(DEPTH)+1  controller writes since last ctrl_active rise; saturating.
- err_ctrl_wr_idle  out  1  sticky: ctrl wren seen while ctrl_active = 0.

Behaviour:
- Reset values:
  - Memory contents are NOT reset.
  - All pipeline valid bits, host_rsp_valid, ctrl_rdata, host_rsp_rdata, ctrl_wr_count and err_ctrl_wr_idle reset to 0.
- Ownership:
  - host_req_ready = !ctrl_active, combinational.
  - Host is never accepted in the cycle ctrl_active is high.
- Controller read:
  - ctrl_in.raddr is sampled every cycle regardless of ctrl_active.
  - ctrl_rdata at cycle t+READ_LATENCY = mem[raddr sampled at t].
  - ctrl_rdata holds the last value in between; no valid signal, the controller tracks latency itself.
- Controller write:
  - If ctrl_in.wren & ctrl_active: mem[waddr] <= wdata at the clock edge.
  - If wren & !ctrl_active: the write is dropped and err_ctrl_wr_idle is set; it clears only on reset.
- Same-address read and write in the same cycle (ctrl or host): read-before-write, i.e. old data is returned (see Optional Feature).
- Host write accepted: mem[addr] <= wdata at that edge. No response.
- Host read accepted at t:
  - host_rsp_valid = 1 for exactly one cycle at t+READ_LATENCY, with data.
  - Back-to-back reads give back-to-back responses, in order.
  - No response backpressure.
- ctrl_active rising while host reads are in flight: those responses still complete on schedule (read pipeline is independent of ownership).
- ctrl_wr_count:
  - Cleared to 0 on the ctrl_active 0->1 edge.
  - Increments on each accepted ctrl write; saturates at DEPTH.
  - Holds after ctrl_active falls.
- Address wrap: addresses are exactly clog2(DEPTH) bits; no out-of-range case exists.
- Reset mid-operation:
  - In-flight host reads are discarded; no rsp_valid follows.
  - Writes in the reset cycle are suppressed.
  - Memory keeps its prior contents.

Optional Feature:
- Macro NTT_BUF_RAW_BYPASS_EN.
- Defined: a read (ctrl or host) issued in the same cycle as an accepted write to the same address returns the new write data (write-first forwarding, compared on the read-issue cycle). Later reads at t+1.. naturally see the new data.
- Not defined: read-before-write; old data is returned.

Decomposition:
- Shared package (FHE_ALU_PKG): BufferRAMTEFsizeInputs struct, BUFFER_READ_LATENCY, E, FSIZE, N-derived DEPTH.
- Latency alignment of read data and host valid bits uses the existing FifoBuffer.
- One natural sub-module: buf_mem_1r1w, a plain 1-read/1-write array with registered read and an optional bypass compare. The top does the ctrl/host muxing, error flag and counter.

Test Plan:
- Reset, ctrl_active = 0: host writes word 0x5 = pattern A, then reads 0x5 -> host_rsp_valid exactly 2 cycles after accept, rdata = A; err = 0.
- ctrl_active = 1, host_req_valid = 1 -> host_req_ready = 0 for whole window; ctrl streams raddr 0..511 -> ctrl_rdata = preloaded word k at cycle k+2; ctrl_wr_count stays 0.
- ctrl writes 128 words, waddr 0..127, during active -> ctrl_wr_count = 128; host readback after ctrl_active falls matches. Second ctrl_active rise -> count = 0.
- ctrl wren = 1 while ctrl_active = 0, waddr 3 -> mem[3] unchanged, err_ctrl_wr_idle = 1 until rstn low.
- Same-cycle ctrl write B and read at address 7 (old value A) -> rdata = A without macro, B with NTT_BUF_RAW_BYPASS_EN.
- Host read accepted, rstn low the next cycle -> no host_rsp_valid ever; memory contents intact on later readback.

Source files
------------

// File: rtl/ntt_buffer_ram_resp_pkg.sv
// Shared buffer-RAM types and sizing for the NTT/iNTT controllers and the buffer responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ntt_buffer_ram_resp_pkg;

    localparam int E                   = 8;
    localparam int FSIZE               = 64;
    localparam int N                   = 4096;
    localparam int DEPTH               = N / E;
    localparam int BUFFER_READ_LATENCY = 2;
    localparam int ADDR_W              = $clog2(DEPTH);
    localparam int WORD_W              = E * FSIZE;

    typedef struct packed {
        logic [ADDR_W-1:0] raddr;
        logic [ADDR_W-1:0] waddr;
        logic              wren;
        logic [WORD_W-1:0] wdata;
    } BufferRAMTEFsizeInputs;

endpackage

// File: rtl/fifo_buffer.sv
// Fixed-depth delay line used to align data/valid bits with a known read latency.
// Latency: STAGES cycles (STAGES = 0 is a wire).
// Backpressure: none; shifts every cycle, contents cleared by reset.
module fifo_buffer #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_dat,
    output logic [WIDTH-1:0] out_dat
);

    generate
        if (STAGES == 0) begin : g_wire
            assign out_dat = in_dat;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe [STAGES];

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= in_dat;
                    for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign out_dat = pipe[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ntt_buffer_ram_resp_mem.sv
// Plain 1R/1W word array with registered read; optional same-address write-first forwarding.
// Latency: 1 cycle rd_addr -> rd_dat.
// Backpressure: none; reads every cycle, array contents are never reset.
module buf_mem_1r1w #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_dat <= '0;
        end else begin
`ifdef NTT_BUF_RAW_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr)) rd_dat <= wr_dat;
            else                               rd_dat <= mem[rd_addr];
`else
            rd_dat <= mem[rd_addr];
`endif
        end
    end

endmodule

// File: rtl/ntt_buffer_ram_resp.sv
// Buffer-RAM responder: controller read/write-back while active, host load/unload while idle.
// Latency: READ_LATENCY for ctrl and host reads; host read-vs-write hazard set by NTT_BUF_RAW_BYPASS_EN.
// Backpressure: host_req_ready = !ctrl_active; no response backpressure.
module ntt_buffer_ram_resp
    import ntt_buffer_ram_resp_pkg::*;
#(
    parameter int E            = ntt_buffer_ram_resp_pkg::E,
    parameter int FSIZE        = ntt_buffer_ram_resp_pkg::FSIZE,
    parameter int DEPTH        = ntt_buffer_ram_resp_pkg::DEPTH,
    parameter int READ_LATENCY = BUFFER_READ_LATENCY
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       ctrl_active,
    input  BufferRAMTEFsizeInputs      ctrl_in,
    output logic [E*FSIZE-1:0]         ctrl_rdata,
    input  logic                       host_req_valid,
    output logic                       host_req_ready,
    input  logic                       host_req_we,
    input  logic [$clog2(DEPTH)-1:0]   host_req_addr,
    input  logic [E*FSIZE-1:0]         host_req_wdata,
    output logic                       host_rsp_valid,
    output logic [E*FSIZE-1:0]         host_rsp_rdata,
    output logic [$clog2(DEPTH):0]     ctrl_wr_count,
    output logic                       err_ctrl_wr_idle
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = E * FSIZE;
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic          host_acc;
    logic          host_wr;
    logic          ctrl_wr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_dat;
    logic [WW-1:0] ctrl_mem_dat;
    logic [WW-1:0] host_mem_dat;
    logic          host_vld_s1;
    logic          active_q;

    assign host_req_ready = !ctrl_active;
    assign host_acc       = host_req_valid && !ctrl_active;
    assign host_wr        = host_acc && host_req_we;
    assign ctrl_wr        = ctrl_in.wren && ctrl_active;

    // Ownership makes ctrl and host writes mutually exclusive; reset suppresses both.
    assign wr_en   = rstn && (ctrl_wr || host_wr);
    assign wr_addr = ctrl_wr ? ctrl_in.waddr : host_req_addr;
    assign wr_dat  = ctrl_wr ? ctrl_in.wdata : host_req_wdata;

    // Two copies with identical writes so ctrl and host reads never contend for a port.
    buf_mem_1r1w #(.WIDTH(WW), .DEPTH(DEPTH)) u_mem_ctrl (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .rd_addr (ctrl_in.raddr),
        .rd_dat  (ctrl_mem_dat)
    );

    buf_mem_1r1w #(.WIDTH(WW), .DEPTH(DEPTH)) u_mem_host (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .rd_addr (host_req_addr),
        .rd_dat  (host_mem_dat)
    );

    always_ff @(posedge clk) begin
        if (!rstn) host_vld_s1 <= 1'b0;
        else       host_vld_s1 <= host_acc && !host_req_we;
    end

    fifo_buffer #(.WIDTH(WW), .STAGES(READ_LATENCY - 1)) u_ctrl_align (
        .clk     (clk),
        .rstn    (rstn),
        .in_dat  (ctrl_mem_dat),
        .out_dat (ctrl_rdata)
    );

    fifo_buffer #(.WIDTH(WW + 1), .STAGES(READ_LATENCY - 1)) u_host_align (
        .clk     (clk),
        .rstn    (rstn),
        .in_dat  ({host_vld_s1, host_mem_dat}),
        .out_dat ({host_rsp_valid, host_rsp_rdata})
    );

    // A write landing in the rise cycle counts toward the new window.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            active_q         <= 1'b0;
            ctrl_wr_count    <= '0;
            err_ctrl_wr_idle <= 1'b0;
        end else begin
            active_q <= ctrl_active;
            if (ctrl_active && !active_q)
                ctrl_wr_count <= ctrl_wr ? CNT_W'(1) : '0;
            else if (ctrl_wr && (ctrl_wr_count != CNT_MAX))
                ctrl_wr_count <= ctrl_wr_count + CNT_W'(1);
            if (ctrl_in.wren && !ctrl_active)
                err_ctrl_wr_idle <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ntt_buffer_ram_resp.sv
// Randomized bench for ntt_buffer_ram_resp against a cycle-log reference model.
// Honours NTT_BUF_RAW_BYPASS_EN when the same macro is defined for the build.
module tb_ntt_buffer_ram_resp;
    import ntt_buffer_ram_resp_pkg::*;

    localparam int LAT  = BUFFER_READ_LATENCY;
    localparam int LOGN = 1024;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  ctrl_active;
    BufferRAMTEFsizeInputs ctrl_in;
    logic [WORD_W-1:0]     ctrl_rdata;
    logic                  host_req_valid;
    logic                  host_req_ready;
    logic                  host_req_we;
    logic [ADDR_W-1:0]     host_req_addr;
    logic [WORD_W-1:0]     host_req_wdata;
    logic                  host_rsp_valid;
    logic [WORD_W-1:0]     host_rsp_rdata;
    logic [ADDR_W:0]       ctrl_wr_count;
    logic                  err_ctrl_wr_idle;

    ntt_buffer_ram_resp dut (
        .clk              (clk),
        .rstn             (rstn),
        .ctrl_active      (ctrl_active),
        .ctrl_in          (ctrl_in),
        .ctrl_rdata       (ctrl_rdata),
        .host_req_valid   (host_req_valid),
        .host_req_ready   (host_req_ready),
        .host_req_we      (host_req_we),
        .host_req_addr    (host_req_addr),
        .host_req_wdata   (host_req_wdata),
        .host_rsp_valid   (host_rsp_valid),
        .host_rsp_rdata   (host_rsp_rdata),
        .ctrl_wr_count    (ctrl_wr_count),
        .err_ctrl_wr_idle (err_ctrl_wr_idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference state: memory contents, which words hold known data, and per-cycle issue log.
    logic [WORD_W-1:0] mdl [DEPTH];
    bit                mk  [DEPTH];
    logic [WORD_W-1:0] log_crd [LOGN];
    bit                log_ck  [LOGN];
    bit                log_hv  [LOGN];
    logic [WORD_W-1:0] log_hrd [LOGN];
    bit                log_rst [LOGN];
    int                m_cnt  = 0;
    bit                m_err  = 0;
    bit                m_prev = 0;

    logic [WORD_W-1:0] exp_crd;
    bit                exp_ck;
    bit                exp_hv;
    logic [WORD_W-1:0] exp_hrd;

    function automatic logic [WORD_W-1:0] rnd_word();
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Record what the current inputs mean, advance one clock, then derive expected outputs.
    task automatic tick();
        int                s;
        bit                c_wr, h_acc, h_wr, any_wr, in_rst;
        logic [ADDR_W-1:0] wa;
        logic [WORD_W-1:0] wd;
        int                t;
        s      = cyc % LOGN;
        c_wr   = rstn && ctrl_in.wren && ctrl_active;
        h_acc  = rstn && host_req_valid && !ctrl_active;
        h_wr   = h_acc && host_req_we;
        any_wr = c_wr || h_wr;
        wa     = c_wr ? ctrl_in.waddr : host_req_addr;
        wd     = c_wr ? ctrl_in.wdata : host_req_wdata;
        log_crd[s] = mdl[ctrl_in.raddr];
        log_ck[s]  = mk[ctrl_in.raddr];
        log_hrd[s] = mdl[host_req_addr];
`ifdef NTT_BUF_RAW_BYPASS_EN
        if (any_wr && wa == ctrl_in.raddr) begin log_crd[s] = wd; log_ck[s] = 1; end
        if (any_wr && wa == host_req_addr) log_hrd[s] = wd;
`endif
        log_hv[s]  = h_acc && !host_req_we;
        log_rst[s] = !rstn;
        if (any_wr) begin mdl[wa] = wd; mk[wa] = 1; end
        if (!rstn) begin
            m_err = 0; m_cnt = 0; m_prev = 0;
        end else begin
            if (ctrl_in.wren && !ctrl_active) m_err = 1;
            if (ctrl_active && !m_prev) m_cnt = 0;
            if (c_wr && m_cnt < DEPTH) m_cnt++;
            m_prev = ctrl_active;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= LAT) begin
            t = cyc - LAT;
            in_rst = 0;
            for (int j = t; j < cyc; j++) if (log_rst[j % LOGN]) in_rst = 1;
            exp_ck  = in_rst ? 1'b1 : log_ck[t % LOGN];
            exp_crd = in_rst ? '0 : log_crd[t % LOGN];
            exp_hv  = !in_rst && log_hv[t % LOGN];
            exp_hrd = log_hrd[t % LOGN];
        end else begin
            exp_ck = 0;
            exp_hv = 0;
        end
    endtask

    task automatic idle_inputs();
        ctrl_in.wren   = 0;
        host_req_valid = 0;
        host_req_we    = 0;
    endtask

    task automatic test_reset();
        rstn = 0; ctrl_active = 0;
        ctrl_in = '0; host_req_addr = '0; host_req_wdata = '0;
        idle_inputs();
        repeat (3) tick();
        n_checks++;
        if (ctrl_rdata !== '0) begin n_fail++; $display("FAIL reset_ctrl_rdata got %h want 0", ctrl_rdata); end
        n_checks++;
        if (host_rsp_valid !== 1'b0 || host_rsp_rdata !== '0) begin
            n_fail++; $display("FAIL reset_host_rsp got vld=%b want vld=0 data=0", host_rsp_valid);
        end
        n_checks++;
        if (ctrl_wr_count !== '0 || err_ctrl_wr_idle !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt_err got cnt=%0d err=%b want 0/0", ctrl_wr_count, err_ctrl_wr_idle);
        end
        rstn = 1;
        tick();
    endtask

    task automatic test_host_basic();
        logic [WORD_W-1:0] a;
        a = rnd_word();
        host_req_valid = 1; host_req_we = 1; host_req_addr = 5; host_req_wdata = a;
        tick();
        host_req_we = 0;
        tick();
        host_req_valid = 0;
        n_checks++;
        if (host_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL host_rsp_early got %b want 0", host_rsp_valid); end
        tick();
        n_checks++;
        if (host_rsp_valid !== 1'b1 || host_rsp_rdata !== a) begin
            n_fail++; $display("FAIL host_rsp_lat2 got vld=%b data=%h want vld=1 data=%h", host_rsp_valid, host_rsp_rdata, a);
        end
        tick();
        n_checks++;
        if (host_rsp_valid !== 1'b0 || err_ctrl_wr_idle !== 1'b0) begin
            n_fail++; $display("FAIL host_rsp_pulse got vld=%b err=%b want 0/0", host_rsp_valid, err_ctrl_wr_idle);
        end
    endtask

    task automatic preload();
        host_req_valid = 1; host_req_we = 1;
        for (int a = 0; a < DEPTH; a++) begin
            host_req_addr = a[ADDR_W-1:0];
            host_req_wdata = rnd_word();
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ctrl_stream();
        ctrl_active = 1; host_req_valid = 1;
        for (int k = 0; k < DEPTH + LAT; k++) begin
            ctrl_in.raddr = (k < DEPTH) ? k[ADDR_W-1:0] : '0;
            host_req_we = 1'($urandom);
            host_req_addr = ADDR_W'($urandom);
            host_req_wdata = rnd_word();
            #1;
            n_checks++;
            if (host_req_ready !== 1'b0) begin n_fail++; $display("FAIL stream_ready k=%0d got %b want 0", k, host_req_ready); end
            tick();
            if (k >= LAT - 1 && exp_ck) begin
                n_checks++;
                if (ctrl_rdata !== exp_crd) begin
                    n_fail++; $display("FAIL stream_rdata k=%0d got %h want %h", k, ctrl_rdata, exp_crd);
                end
            end
        end
        n_checks++;
        if (ctrl_wr_count !== '0 || host_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_cnt got cnt=%0d vld=%b want 0/0", ctrl_wr_count, host_rsp_valid);
        end
        ctrl_active = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_ctrl_write();
        ctrl_active = 1;
        tick();
        for (int i = 0; i < 128; i++) begin
            ctrl_in.wren = 1; ctrl_in.waddr = i[ADDR_W-1:0]; ctrl_in.wdata = rnd_word();
            ctrl_in.raddr = ADDR_W'($urandom);
            tick();
            n_checks++;
            if (exp_ck && ctrl_rdata !== exp_crd) begin
                n_fail++; $display("FAIL wr_rdata i=%0d got %h want %h", i, ctrl_rdata, exp_crd);
            end
        end
        ctrl_in.wren = 0;
        tick();
        n_checks++;
        if (ctrl_wr_count !== 10'd128) begin n_fail++; $display("FAIL wr_count got %0d want 128", ctrl_wr_count); end
        ctrl_active = 0;
        tick();
        for (int i = 0; i < 128 + LAT; i++) begin
            host_req_valid = (i < 128); host_req_we = 0; host_req_addr = i[ADDR_W-1:0];
            tick();
            n_checks++;
            if (host_rsp_valid !== exp_hv || (exp_hv && host_rsp_rdata !== exp_hrd)) begin
                n_fail++; $display("FAIL wr_readback i=%0d got vld=%b data=%h want vld=%b data=%h",
                                   i, host_rsp_valid, host_rsp_rdata, exp_hv, exp_hrd);
            end
        end
        n_checks++;
        if (ctrl_wr_count !== 10'd128) begin n_fail++; $display("FAIL wr_count_hold got %0d want 128", ctrl_wr_count); end
        idle_inputs();
        ctrl_active = 1;
        tick();
        n_checks++;
        if (ctrl_wr_count !== '0) begin n_fail++; $display("FAIL wr_count_rise got %0d want 0", ctrl_wr_count); end
        for (int i = 0; i < DEPTH + 3; i++) begin
            ctrl_in.wren = 1; ctrl_in.waddr = ADDR_W'($urandom); ctrl_in.wdata = rnd_word();
            tick();
        end
        ctrl_in.wren = 0;
        tick();
        n_checks++;
        if (ctrl_wr_count !== m_cnt[ADDR_W:0] || m_cnt != DEPTH) begin
            n_fail++; $display("FAIL wr_count_sat got %0d want %0d", ctrl_wr_count, DEPTH);
        end
        ctrl_active = 0;
        tick();
    endtask

    task automatic test_idle_write();
        logic [WORD_W-1:0] old;
        old = mdl[3];
        ctrl_in.wren = 1; ctrl_in.waddr = 3; ctrl_in.wdata = ~old;
        tick();
        ctrl_in.wren = 0;
        host_req_valid = 1; host_req_we = 0; host_req_addr = 3;
        tick();
        host_req_valid = 0;
        n_checks++;
        if (err_ctrl_wr_idle !== 1'b1) begin n_fail++; $display("FAIL idle_err got %b want 1", err_ctrl_wr_idle); end
        repeat (LAT) tick();
        n_checks++;
        if (host_rsp_valid !== 1'b0 || host_rsp_rdata !== old) begin
            n_fail++; $display("FAIL idle_mem3 got %h want %h", host_rsp_rdata, old);
        end
        repeat (5) tick();
        n_checks++;
        if (err_ctrl_wr_idle !== 1'b1) begin n_fail++; $display("FAIL idle_err_sticky got %b want 1", err_ctrl_wr_idle); end
    endtask

    task automatic test_raw();
        logic [WORD_W-1:0] a, b, want;
        ctrl_active = 1;
        tick();
        a = mdl[7]; b = rnd_word();
        ctrl_in.raddr = 7; ctrl_in.waddr = 7; ctrl_in.wren = 1; ctrl_in.wdata = b;
        tick();
        ctrl_in.wren = 0;
        tick();
`ifdef NTT_BUF_RAW_BYPASS_EN
        want = b;
`else
        want = a;
`endif
        n_checks++;
        if (ctrl_rdata !== want) begin n_fail++; $display("FAIL raw_ctrl got %h want %h", ctrl_rdata, want); end
        tick();
        n_checks++;
        if (ctrl_rdata !== b) begin n_fail++; $display("FAIL raw_ctrl_after got %h want %h", ctrl_rdata, b); end
        ctrl_active = 0;
        tick();
        a = mdl[9]; b = rnd_word();
        ctrl_in.raddr = 9;
        host_req_valid = 1; host_req_we = 1; host_req_addr = 9; host_req_wdata = b;
        tick();
        idle_inputs();
        tick();
`ifdef NTT_BUF_RAW_BYPASS_EN
        want = b;
`else
        want = a;
`endif
        n_checks++;
        if (ctrl_rdata !== want) begin n_fail++; $display("FAIL raw_host_wr got %h want %h", ctrl_rdata, want); end
    endtask

    task automatic test_reset_mid();
        logic [WORD_W-1:0] keep;
        keep = mdl[20];
        host_req_valid = 1; host_req_we = 0; host_req_addr = 20;
        tick();
        host_req_valid = 1; host_req_we = 1; host_req_addr = 20; host_req_wdata = ~keep;
        rstn = 0;
        tick();
        idle_inputs();
        rstn = 1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (host_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_rsp i=%0d got %b want 0", i, host_rsp_valid); end
            tick();
        end
        n_checks++;
        if (err_ctrl_wr_idle !== 1'b0 || ctrl_wr_count !== '0) begin
            n_fail++; $display("FAIL rstmid_clear got err=%b cnt=%0d want 0/0", err_ctrl_wr_idle, ctrl_wr_count);
        end
        host_req_valid = 1; host_req_we = 0; host_req_addr = 20;
        tick();
        host_req_valid = 0;
        repeat (LAT - 1) tick();
        n_checks++;
        if (host_rsp_valid !== 1'b1 || host_rsp_rdata !== keep) begin
            n_fail++; $display("FAIL rstmid_mem got vld=%b data=%h want vld=1 data=%h", host_rsp_valid, host_rsp_rdata, keep);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) ctrl_active = !ctrl_active;
            ctrl_in.raddr  = ADDR_W'($urandom);
            ctrl_in.waddr  = ADDR_W'($urandom_range(15));
            ctrl_in.wdata  = rnd_word();
            ctrl_in.wren   = ctrl_active ? 1'($urandom) : ($urandom_range(63) == 0);
            host_req_valid = 1'($urandom);
            host_req_we    = ($urandom_range(3) == 0);
            host_req_addr  = ADDR_W'($urandom_range(15));
            host_req_wdata = rnd_word();
            #1;
            n_checks++;
            if (host_req_ready !== !ctrl_active) begin
                n_fail++; $display("FAIL rnd_ready i=%0d got %b want %b", i, host_req_ready, !ctrl_active);
            end
            tick();
            n_checks++;
            if ((exp_ck && ctrl_rdata !== exp_crd) || host_rsp_valid !== exp_hv ||
                (exp_hv && host_rsp_rdata !== exp_hrd)) begin
                n_fail++; $display("FAIL rnd_data i=%0d got crd=%h vld=%b want crd=%h vld=%b",
                                   i, ctrl_rdata, host_rsp_valid, exp_crd, exp_hv);
            end
            n_checks++;
            if (ctrl_wr_count !== m_cnt[ADDR_W:0] || err_ctrl_wr_idle !== m_err) begin
                n_fail++; $display("FAIL rnd_cnt_err i=%0d got cnt=%0d err=%b want cnt=%0d err=%b",
                                   i, ctrl_wr_count, err_ctrl_wr_idle, m_cnt, m_err);
            end
        end
        idle_inputs();
        ctrl_active = 0;
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host_basic();
        preload();
        test_ctrl_stream();
        test_ctrl_write();
        test_idle_write();
        test_raw();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
